// File: rtl/fetch_queue.sv
// fetch_queue: decoupled RV32 fetch stage with an instruction queue toward decode.
// Issues sequential fetches over a req/ack handshake and follows predictor hits
// and JALs without a bubble. Execute-stage redirects flush the queue and drop
// any in-flight response.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_req/imem_addr         registered fetch request and address
//   imem_ack/imem_rdata        memory response (may ack in the request cycle)
//   predict_valid/predict_addr predicted next PC for the acked address
//   redirect_valid/redirect_addr execute-stage redirect, highest priority
//   dec_valid/dec_instr/dec_pc queue head toward decode; dec_ready pops it
module fetch_queue #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             predict_valid,
    input  logic [WIDTH-1:0] predict_addr,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_addr,
    output logic             dec_valid,
    output logic [31:0]      dec_instr,
    output logic [WIDTH-1:0] dec_pc,
    input  logic             dec_ready
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [6:0]  OP_JAL = 7'b1101111;

    typedef enum logic {RUN, DROP} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] pc, pc_next, addr_next, jal_target;
    logic             req_next, dec_valid_next;
    logic [CNT_W-1:0] count, count_next;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic             handshake, push, pop;

    logic [WIDTH-1:0] pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];

    // JAL target: J-type immediate sign-extended from bit 20 to WIDTH
    always_comb begin
        jal_target = pc + {{(WIDTH-21){imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                           imem_rdata[20], imem_rdata[30:21], 1'b0};
    end

    // Next-state, queue bookkeeping and request generation
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        req_next    = imem_req;
        addr_next   = imem_addr;
        count_next  = count;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        handshake   = imem_req & imem_ack;
        push        = 1'b0;
        pop         = dec_valid & dec_ready;

        if (redirect_valid) begin
            // Flush: pop and any same-edge response are ignored
            pop         = 1'b0;
            pc_next     = redirect_addr;
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            if (state == DROP) begin
                if (handshake) begin
                    state_next = RUN;
                    req_next   = 1'b1;
                    addr_next  = redirect_addr;
                end
            end else if (imem_req && !imem_ack) begin
                // Outstanding request keeps its address; its response is dropped later
                state_next = DROP;
            end else begin
                req_next  = 1'b1;
                addr_next = redirect_addr;
            end
        end else begin
            push = (state == RUN) && handshake;
            if (push) begin
                if (predict_valid)
                    pc_next = predict_addr;
                else if (imem_rdata[6:0] == OP_JAL)
                    pc_next = jal_target;
                else
                    pc_next = pc + WIDTH'(4);
                wr_ptr_next = wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr_next = rd_ptr + PTR_W'(1);
            count_next = count + CNT_W'(push) - CNT_W'(pop);

            if (state == DROP && handshake) begin
                state_next = RUN;
                req_next   = 1'b1;
                addr_next  = pc_next;
            end else if (imem_req && !imem_ack) begin
                req_next  = 1'b1;
                addr_next = imem_addr;
            end else begin
                req_next  = (count_next < CNT_W'(DEPTH));
                addr_next = pc_next;
            end
        end
        dec_valid_next = (count_next != '0);
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dec_valid <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            imem_req  <= req_next;
            imem_addr <= addr_next;
            count     <= count_next;
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            dec_valid <= dec_valid_next;
        end
    end

    // Queue storage; push is already suppressed on redirect and in DROP
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_q[wr_ptr]    <= pc;
            instr_q[wr_ptr] <= imem_rdata;
        end
    end

    assign dec_pc    = pc_q[rd_ptr];
    assign dec_instr = instr_q[rd_ptr];

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (WIDTH=32, DEPTH=4, RESET_PC=0).
// A small ROM answers fetches; ack is gated by ack_en so latency can be stretched.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        predict_valid;
    logic [31:0] predict_addr;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;

    logic        ack_en;
    logic [31:0] rom [256];
    int          total = 0;
    int          bad   = 0;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JAL_P16  = 32'h0100_006F;
    localparam logic [31:0] JAL_M4   = 32'hFFDF_F06F;

    always #5 clk = ~clk;

    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = rom[imem_addr[9:2]];

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .predict_valid (predict_valid),
        .predict_addr  (predict_addr),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_ready     (dec_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = NOP;
        rom[8'h02] = JAL_P16;   // 0x08: jal +16 -> 0x18
        rom[8'h04] = JAL_P16;   // 0x10: jal, but predictor overrides
        rom[8'h08] = JAL_M4;    // 0x20: jal -4 -> 0x1C

        reset = 1'b1; ack_en = 1'b1; dec_ready = 1'b1;
        predict_valid = 1'b0; predict_addr = '0;
        redirect_valid = 1'b0; redirect_addr = '0;

        step(); step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(dec_valid), 32'd0);
        reset = 1'b0;

        // Sequential fetch with zero-wait memory
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        check("first_valid", 32'(dec_valid), 32'd0);
        step();
        check("seq_addr4", imem_addr, 32'h4);
        check("seq_valid", 32'(dec_valid), 32'd1);
        check("seq_pc0", dec_pc, 32'h0);
        check("seq_instr", dec_instr, NOP);
        step();
        check("seq_addr8", imem_addr, 32'h8);
        check("seq_pc4", dec_pc, 32'h4);
        // JAL forward and backward
        step();
        check("jal_fwd_addr", imem_addr, 32'h18);
        check("jal_fwd_instr", dec_instr, JAL_P16);
        step();
        check("after_jal_addr", imem_addr, 32'h1C);
        check("after_jal_pc", dec_pc, 32'h18);
        step();
        check("seq_addr20", imem_addr, 32'h20);
        step();
        check("jal_back_addr", imem_addr, 32'h1C);
        check("jal_back_pc", dec_pc, 32'h20);
        ack_en = 1'b0;
        step();
        check("stall_req", 32'(imem_req), 32'd1);
        check("stall_addr", imem_addr, 32'h1C);
        check("drained_valid", 32'(dec_valid), 32'd0);

        // Fill the queue with decode stalled
        ack_en = 1'b1; dec_ready = 1'b0;
        step(); step(); step(); step();
        check("full_req", 32'(imem_req), 32'd0);
        check("full_valid", 32'(dec_valid), 32'd1);
        check("full_head", dec_pc, 32'h1C);
        step();
        check("full_hold_req", 32'(imem_req), 32'd0);
        dec_ready = 1'b1;
        step();
        check("pop1_req", 32'(imem_req), 32'd1);
        check("pop1_addr", imem_addr, 32'h1C);
        check("pop1_head", dec_pc, 32'h20);
        dec_ready = 1'b0;
        step();
        check("refill_req", 32'(imem_req), 32'd0);
        check("refill_head", dec_pc, 32'h20);
        ack_en = 1'b0; dec_ready = 1'b1;
        step();
        check("drain_head1", dec_pc, 32'h1C);
        step();
        check("drain_head2", dec_pc, 32'h20);
        step();
        check("drain_head3", dec_pc, 32'h1C);
        check("drain_valid3", 32'(dec_valid), 32'd1);
        step();
        check("drain_empty", 32'(dec_valid), 32'd0);
        check("drain_req", 32'(imem_req), 32'd1);
        check("drain_addr", imem_addr, 32'h20);

        // Redirect while a request is outstanding, then predictor beats JAL
        redirect_valid = 1'b1; redirect_addr = 32'h10;
        step();
        check("drop_hold_addr", imem_addr, 32'h20);
        check("drop_hold_req", 32'(imem_req), 32'd1);
        redirect_valid = 1'b0; ack_en = 1'b1;
        step();
        check("drop_discard_valid", 32'(dec_valid), 32'd0);
        check("drop_next_addr", imem_addr, 32'h10);
        predict_valid = 1'b1; predict_addr = 32'h400;
        step();
        check("predict_addr", imem_addr, 32'h400);
        check("predict_pc", dec_pc, 32'h10);
        check("predict_instr", dec_instr, JAL_P16);
        predict_valid = 1'b0; ack_en = 1'b0;
        step();
        check("predict_pop", 32'(dec_valid), 32'd0);

        // Slow memory: pending fetch at 0x40 redirected to 0x200
        redirect_valid = 1'b1; redirect_addr = 32'h40;
        step();
        redirect_valid = 1'b0; ack_en = 1'b1;
        step();
        check("slow_req_addr", imem_addr, 32'h40);
        ack_en = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_addr = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("slow_hold1", imem_addr, 32'h40);
        check("slow_empty", 32'(dec_valid), 32'd0);
        step();
        check("slow_hold2", imem_addr, 32'h40);
        check("slow_hold2_req", 32'(imem_req), 32'd1);
        ack_en = 1'b1; dec_ready = 1'b0;
        step();
        check("slow_dropped", 32'(dec_valid), 32'd0);
        check("slow_new_addr", imem_addr, 32'h200);
        step();
        check("slow_push_valid", 32'(dec_valid), 32'd1);
        check("slow_push_pc", dec_pc, 32'h200);
        step();
        check("two_entries_head", dec_pc, 32'h200);
        check("two_entries_addr", imem_addr, 32'h208);

        // Redirect coincident with ack and pop, two entries queued
        redirect_valid = 1'b1; redirect_addr = 32'h300; dec_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("coinc_valid", 32'(dec_valid), 32'd0);
        check("coinc_req", 32'(imem_req), 32'd1);
        check("coinc_addr", imem_addr, 32'h300);
        step();
        check("coinc_push_valid", 32'(dec_valid), 32'd1);
        check("coinc_push_pc", dec_pc, 32'h300);
        check("coinc_next_addr", imem_addr, 32'h304);

        // Reset mid-operation
        reset = 1'b1;
        step();
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_valid", 32'(dec_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
